// File: rtl/song_display_banked.sv
// Banked song display: PAGES pages of STEPS note slots, one page shown on a registered bus.
// Optional PAGE_CLEAR_EN builds a per-page clear driven by clr.
module song_display_banked #(
  parameter int NOTE_W = 2,
  parameter int STEPS = 16,
  parameter int PAGES = 4,
  parameter int SCROLL_TICKS = 8,
  localparam int PAGE_W = STEPS * NOTE_W,
  localparam int PG_W = $clog2(PAGES),
  localparam int POS_W = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              toggle,
  input  logic              tick,
  input  logic              wr_en,
  input  logic [PG_W-1:0]   wr_page,
  input  logic [POS_W-1:0]  wr_pos,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic              clr,
  output logic [PAGE_W-1:0] current_note,
  output logic [PG_W-1:0]   page_idx,
  output logic              page_wrap
);

  localparam int CNT_W = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    AUTO   = 2'b01,
    HOLD   = 2'b10,
    BLANK  = 2'b11
  } mode_e;

  mode_e             mode_d, mode_q;
  logic              toggle_q;
  logic [PG_W-1:0]   page_idx_d, page_idx_q;
  logic [CNT_W-1:0]  tick_cnt_d, tick_cnt_q;
  logic              page_wrap_d, page_wrap_q;
  logic [PAGE_W-1:0] note_d, note_q;
  logic [PAGE_W-1:0] mem_d [PAGES];
  logic [PAGE_W-1:0] mem_q [PAGES];
  logic              rise, last_tick, last_page, advance;

  assign mode_d = mode_e'(mode);

  // Advance is decided by the registered mode; a mode change only clears the tick count.
  always_comb begin
    rise       = toggle & ~toggle_q;
    last_tick  = 32'(tick_cnt_q) == 32'(SCROLL_TICKS - 1);
    last_page  = 32'(page_idx_q) == 32'(PAGES - 1);
    advance    = 1'b0;
    tick_cnt_d = tick_cnt_q;
    unique case (mode_q)
      MANUAL: advance = rise;
      AUTO: begin
        if (tick) begin
          advance    = last_tick;
          tick_cnt_d = last_tick ? '0 : tick_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    if (mode_d != mode_q) tick_cnt_d = '0;
    page_idx_d = page_idx_q;
    if (advance) page_idx_d = last_page ? '0 : page_idx_q + PG_W'(1);
    page_wrap_d = advance & last_page;
    note_d = (mode_d == BLANK) ? '0 : mem_q[page_idx_q];
  end

  always_comb begin
    for (int p = 0; p < PAGES; p++) begin
      mem_d[p] = mem_q[p];
      if (wr_en && 32'(wr_page) == 32'(p)) begin
        for (int s = 0; s < STEPS; s++) begin
          if (32'(wr_pos) == 32'(s)) mem_d[p][s*NOTE_W +: NOTE_W] = wr_note;
        end
      end
`ifdef PAGE_CLEAR_EN
      if (clr && 32'(wr_page) == 32'(p)) mem_d[p] = '0;
`endif
    end
  end

`ifndef PAGE_CLEAR_EN
  logic unused_clr;
  assign unused_clr = clr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MANUAL;
      toggle_q    <= 1'b0;
      page_idx_q  <= '0;
      tick_cnt_q  <= '0;
      page_wrap_q <= 1'b0;
      note_q      <= '0;
      for (int p = 0; p < PAGES; p++) mem_q[p] <= '0;
    end else begin
      mode_q      <= mode_d;
      toggle_q    <= toggle;
      page_idx_q  <= page_idx_d;
      tick_cnt_q  <= tick_cnt_d;
      page_wrap_q <= page_wrap_d;
      note_q      <= note_d;
      for (int p = 0; p < PAGES; p++) mem_q[p] <= mem_d[p];
    end
  end

  assign current_note = note_q;
  assign page_idx     = page_idx_q;
  assign page_wrap    = page_wrap_q;

endmodule
